// File: rtl/midterm_pkg.sv
// midterm_pkg: shared state encoding, nibble slot indices and word width
package midterm_pkg;
    localparam int WORD_W = 16;
    localparam int NIB_W  = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_DONE,
        S_FULL
    } state_t;

    // Matrix elements arrive a, c, d, b; slot index picks the nibble lane
    typedef logic [1:0] slot_t;
    localparam slot_t SLOT_A = 2'd0;
    localparam slot_t SLOT_C = 2'd1;
    localparam slot_t SLOT_D = 2'd2;
    localparam slot_t SLOT_B = 2'd3;
endpackage

// File: rtl/midterm_ram.sv
// midterm_ram: DEPTH x 16 store, one synchronous write port, one asynchronous read port
module midterm_ram
    import midterm_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [WORD_W-1:0] rd_data
);
    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
    end

    // Async read sees the pre-edge contents during a same-cycle write
    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/midterm_ram_writer.sv
// midterm_ram_writer: packs a nibble stream into 16-bit words and stores them
// sequentially in a local RAM read combinationally by the determinant core.
module midterm_ram_writer
    import midterm_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [3:0]        in_nib,
    input  logic              in_last,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic              full,
    output logic [AW:0]       wr_count,
    input  logic [AW-1:0]     rd_addr,
    output logic [WORD_W-1:0] rd_data
);
    state_t            state, next;
    logic [AW-1:0]     addr;
    slot_t             slot;
    logic [WORD_W-1:0] word;
    logic              last_q;
    logic              accept;
    logic              we;
    logic              idle_like;

    assign accept    = in_valid && in_ready;
    assign idle_like = state inside {S_IDLE, S_DONE, S_FULL};

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= next;
    end

    always_comb begin
        next = state;
        unique case (state)
            S_IDLE, S_DONE, S_FULL: next = start ? S_COLLECT : state;
            S_COLLECT: next = (accept && (slot == SLOT_B || in_last)) ? S_WRITE : S_COLLECT;
            S_WRITE:   next = last_q ? S_DONE : (&addr) ? S_FULL : S_COLLECT;
            default:   next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = state == S_COLLECT;
        busy     = state == S_COLLECT || state == S_WRITE;
        done     = state == S_DONE;
        full     = state == S_FULL;
        we       = state == S_WRITE;
    end

    // word is zeroed between words so a short final word pads high nibbles with 0
    always_ff @(posedge clk) begin
        if (reset) begin
            addr     <= '0;
            slot     <= SLOT_A;
            word     <= '0;
            last_q   <= 1'b0;
            wr_count <= '0;
        end else if (idle_like && start) begin
            addr     <= '0;
            slot     <= SLOT_A;
            word     <= '0;
            last_q   <= 1'b0;
            wr_count <= '0;
        end else if (state == S_COLLECT && accept) begin
            word[{slot, 2'b00} +: NIB_W] <= in_nib;
            slot   <= slot + 2'd1;
            last_q <= in_last;
        end else if (state == S_WRITE) begin
            wr_count <= wr_count + 1'b1;
            slot     <= SLOT_A;
            word     <= '0;
            if (!last_q && !(&addr)) addr <= addr + 1'b1;
        end
    end

    midterm_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk     (clk),
        .we      (we),
        .wr_addr (addr),
        .wr_data (word),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );
endmodule

// File: tb/tb_midterm_ram_writer.sv
// tb_midterm_ram_writer: directed self-checking bench for midterm_ram_writer
module tb_midterm_ram_writer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  in_nib = 4'h0;
    logic        in_last = 1'b0;
    logic        in_ready, busy, done, full;
    logic [8:0]  wr_count;
    logic [7:0]  rd_addr = 8'h00;
    logic [15:0] rd_data;
    int          total = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    midterm_ram_writer #(.DEPTH(256), .AW(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .in_nib   (in_nib),
        .in_last  (in_last),
        .in_ready (in_ready),
        .busy     (busy),
        .done     (done),
        .full     (full),
        .wr_count (wr_count),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mem_check(input string tag, input logic [7:0] a, input logic [15:0] exp);
        rd_addr = a;
        #1;
        check(tag, {16'h0, rd_data}, {16'h0, exp});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer one nibble at a negedge, wait (bounded) for in_ready, let one edge accept it
    task automatic send(input logic [3:0] n, input logic l);
        int k = 0;
        in_valid = 1'b1;
        in_nib   = n;
        in_last  = l;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            total++;
            fails++;
            $error("FAIL ready_wait: in_ready stuck at %0b, expected 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_full", full, 0);
        check("rst_count", wr_count, 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_hold", busy, 0);

        // Single word 3,2,1,4 with last; start pulsed during WRITE is ignored
        pulse_start();
        check("col_ready", in_ready, 1);
        check("col_busy", busy, 1);
        send(4'h3, 0); send(4'h2, 0); send(4'h1, 0); send(4'h4, 1);
        check("wr_busy", busy, 1);
        check("wr_ready", in_ready, 0);
        check("wr_done", done, 0);
        pulse_start();
        check("t1_done", done, 1);
        check("t1_busy", busy, 0);
        check("t1_count", wr_count, 1);
        mem_check("t1_mem0", 8'd0, 16'h4123);
        @(negedge clk);
        check("t1_hold", done, 1);

        // Start from DONE, eight gapped nibbles
        pulse_start();
        check("t2_done_clr", done, 0);
        check("t2_count_clr", wr_count, 0);
        check("t2_ready", in_ready, 1);
        for (int i = 1; i <= 8; i++) begin
            send(4'(i), i == 8);
            @(negedge clk);
        end
        check("t2_done", done, 1);
        check("t2_count", wr_count, 2);
        mem_check("t2_mem0", 8'd0, 16'h4321);
        mem_check("t2_mem1", 8'd1, 16'h8765);

        // Partial word: high nibbles zero
        pulse_start();
        send(4'h5, 0); send(4'h6, 1);
        @(negedge clk);
        check("t3_done", done, 1);
        check("t3_count", wr_count, 1);
        mem_check("t3_mem0", 8'd0, 16'h0065);
        mem_check("t3_mem1", 8'd1, 16'h8765);

        // Reset mid-collect discards partial word
        pulse_start();
        send(4'h9, 0); send(4'hA, 0);
        check("t4_busy_pre", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t4_busy", busy, 0);
        check("t4_ready", in_ready, 0);
        check("t4_count", wr_count, 0);
        check("t4_done", done, 0);
        mem_check("t4_mem0", 8'd0, 16'h0065);
        @(negedge clk);
        mem_check("t4_mem0_late", 8'd0, 16'h0065);
        pulse_start();
        send(4'h1, 0); send(4'h2, 0); send(4'h3, 0); send(4'h4, 1);
        @(negedge clk);
        mem_check("t4_slot_clr", 8'd0, 16'h4321);

        // Fill all 256 words without last
        pulse_start();
        for (int i = 0; i < 1024; i++) send(4'(i), 0);
        check("t5_wr_busy", busy, 1);
        @(negedge clk);
        check("t5_full", full, 1);
        check("t5_done", done, 0);
        check("t5_ready", in_ready, 0);
        check("t5_busy", busy, 0);
        check("t5_count", wr_count, 256);
        mem_check("t5_mem0", 8'd0, 16'h3210);
        mem_check("t5_mem1", 8'd1, 16'h7654);
        mem_check("t5_mem255", 8'd255, 16'hFEDC);
        in_valid = 1'b1;
        in_nib   = 4'h7;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        check("t5_1025_count", wr_count, 256);
        check("t5_1025_full", full, 1);
        mem_check("t5_1025_mem0", 8'd0, 16'h3210);

        // Last nibble on word 255: done wins over full
        pulse_start();
        check("t6_full_clr", full, 0);
        for (int i = 0; i < 1024; i++) send(4'(i + 1), i == 1023);
        @(negedge clk);
        check("t6_done", done, 1);
        check("t6_full", full, 0);
        check("t6_count", wr_count, 256);
        mem_check("t6_mem0", 8'd0, 16'h4321);
        mem_check("t6_mem255", 8'd255, 16'h0FED);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
